// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control sequencer for the multi-cycle CPU datapath.
// It issues one instruction over FETCH, DECODE, then 1-3 execute/memory/writeback
// states. Memory states stretch until the unified memory reports completion.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   opcode, funct      instruction fields held in the instruction register
//   alu_zero           ALU zero flag, used by BNE in BRANCH
//   mem_ready          unified memory finishes the current access this cycle
//   pc_write, pc_src   PC load enable and PC source select
//   iord               memory address select (0=PC)
//   ir_write           instruction register load
//   mem_read/mem_write memory requests
//   reg_write, reg_dst, mem_to_reg   register-file write controls
//   alu_src_a, alu_src_b, alu_ctrl   ALU operand selects and operation
//   state              current state code (debug)
//   instr_done         pulse on the last cycle of each instruction
//   halted             high while parked in HALT
//
// state    | meaning
// IDLE     | after reset, all outputs 0
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | precompute branch target, dispatch on opcode/funct
// MEM_ADDR | ALUOut <- A + sign-ext imm
// MEM_RD   | load read, wait for mem_ready
// MEM_WB   | MDR -> Rt
// MEM_WR   | store write, wait for mem_ready
// EXEC_R   | R-type ALU operation
// R_WB     | ALUOut -> Rd
// EXEC_I   | immediate ALU operation
// I_WB     | ALUOut -> Rt
// BRANCH   | BNE compare, load target if not equal
// JUMP     | load jump target
// JAL_WB   | PC+4 -> r31, load jump target
// JR       | Rs -> PC
// HALT     | parked, left only by reset
module multicycle_ctrl #(
  parameter logic ADDR_FROM_ALUOUT = 1'b1,
  parameter logic ILLEGAL_HALT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL_WB   = 4'd13,
    S_JR       = 4'd14,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_ctrl   = 3'd0;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_BNE:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL_WB;
          OP_RTYPE: begin
            case (funct)
              FN_JR:                          state_d = S_JR;
              FN_ADD, FN_SUB, FN_SLT, FN_XOR: state_d = S_EXEC_R;
              default: begin
                state_d    = ILLEGAL_HALT ? S_HALT : S_FETCH;
                instr_done = ~ILLEGAL_HALT;
              end
            endcase
          end
          default: begin
            state_d    = ILLEGAL_HALT ? S_HALT : S_FETCH;
            instr_done = ~ILLEGAL_HALT;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        // Only LW and SW reach this state; anything not LW is a store.
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iord     = ADDR_FROM_ALUOUT;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        iord      = ADDR_FROM_ALUOUT;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_SUB:  alu_ctrl = 3'd1;
          FN_XOR:  alu_ctrl = 3'd2;
          FN_SLT:  alu_ctrl = 3'd3;
          default: alu_ctrl = 3'd0;
        endcase
        state_d = S_R_WB;
      end

      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_ctrl  = (opcode == OP_XORI) ? 3'd2 : 3'd0;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = 3'd1;
        pc_src     = 2'd1;
        pc_write   = ~alu_zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // PC already holds PC+4 from FETCH, so r31 and the PC load share this cycle.
      S_JAL_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'd3;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule
